// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops bytes from a show-ahead FIFO and
// sends them as 8N1 (optionally 8E1) frames on a registered tx pin.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_PRE  = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic            r_par;
  logic            r_tx;
  logic            r_done;

  logic            w_bit_end;
  logic            w_pop_slot;
  logic            w_pop;

  assign w_bit_end  = (r_cnt == C_LAST);
  assign w_pop_slot = (r_state == S_IDLE) ||
                      ((r_state == S_STOP) && w_bit_end);
  // Pop is gated by rst_n so the FIFO never sees a strobe in reset.
  assign w_pop      = rst_n & enable & ~fifo_empty & w_pop_slot;

  assign fifo_rd_en = w_pop;
  assign tx         = r_tx;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_done;

  // Frame sequencer: bit timing, shifting and registered line/pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE || w_bit_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_pop) begin
        r_state <= S_START;
        r_tx    <= 1'b0;
        r_shift <= fifo_data;
        r_par   <= ^fifo_data;
        r_idx   <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_tx <= 1'b1;
          end
          S_START: begin
            if (w_bit_end) begin
              r_state <= S_DATA;
              r_tx    <= r_shift[0];
              r_idx   <= '0;
            end
          end
          S_DATA: begin
            if (w_bit_end) begin
              if (r_idx == 3'd7) begin
                r_idx <= '0;
                if (PARITY_EN != 0) begin
                  r_state <= S_PARITY;
                  r_tx    <= r_par;
                end else begin
                  r_state <= S_STOP;
                  r_tx    <= 1'b1;
                end
              end else begin
                r_idx   <= r_idx + 3'd1;
                r_shift <= {1'b0, r_shift[7:1]};
                r_tx    <= r_shift[1];
              end
            end
          end
          S_PARITY: begin
            if (w_bit_end) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end
          end
          S_STOP: begin
            // Raise done so it lands on the final stop cycle.
            if (r_cnt == C_PRE) begin
              r_done <= 1'b1;
            end
            if (w_bit_end) begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
